// File: rtl/ws2812_pkg.sv
// Shared types and default 50 MHz timing constants for the WS2812 serial encoder.
package ws2812_pkg;

    localparam int unsigned WORD_BITS = 24;

    localparam int unsigned DFLT_T0H_CYC   = 20;
    localparam int unsigned DFLT_T1H_CYC   = 40;
    localparam int unsigned DFLT_BIT_CYC   = 62;
    localparam int unsigned DFLT_RESET_CYC = 14000;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow,
        StGuard
    } ws_state_e;

endpackage

// File: rtl/ws2812_tx_encoder.sv
// WS2812 single-wire NRZ encoder: streams 24-bit words MSB first, back to back while tx_en holds.
// Optional WS2812_RESET_GUARD_EN inserts a RESET_CYC idle-low guard before IDLE.
module ws2812_tx_encoder
    import ws2812_pkg::*;
#(
    parameter int unsigned T0H_CYC   = DFLT_T0H_CYC,
    parameter int unsigned T1H_CYC   = DFLT_T1H_CYC,
    parameter int unsigned BIT_CYC   = DFLT_BIT_CYC,
    parameter int unsigned RESET_CYC = DFLT_RESET_CYC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_en,
    input  logic [WORD_BITS-1:0] RGB,
    output logic                 tx_done,
    output logic                 dout
);

    localparam int unsigned CntW = $clog2(BIT_CYC);

    // Terminal counts for each phase; counter starts at 0 on every state entry.
    localparam logic [CntW-1:0] T0hLast = CntW'(T0H_CYC - 1);
    localparam logic [CntW-1:0] T1hLast = CntW'(T1H_CYC - 1);
    localparam logic [CntW-1:0] L0Last  = CntW'(BIT_CYC - T0H_CYC - 1);
    localparam logic [CntW-1:0] L1Last  = CntW'(BIT_CYC - T1H_CYC - 1);
    localparam logic [4:0]      IdxTop  = 5'(WORD_BITS - 1);

    if (BIT_CYC <= T1H_CYC + 2 || T0H_CYC == 0 || T0H_CYC >= T1H_CYC || RESET_CYC < 2)
    begin : g_bad_cfg
        $error("ws2812_tx_encoder: inconsistent timing parameters");
    end

    ws_state_e              state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [WORD_BITS-1:0]   sr_q, sr_d;
    logic [4:0]             idx_q, idx_d;
    logic                   dout_q, dout_d;
    logic                   done_q, done_d;
    logic [CntW-1:0]        th_last, lo_last;

`ifdef WS2812_RESET_GUARD_EN
    localparam int unsigned GuardW = $clog2(RESET_CYC);
    localparam logic [GuardW-1:0] GuardLast = GuardW'(RESET_CYC - 1);
    localparam ws_state_e EndState = StGuard;

    logic [GuardW-1:0] guard_q, guard_d;
`else
    localparam ws_state_e EndState = StIdle;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        sr_d    = sr_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
`ifdef WS2812_RESET_GUARD_EN
        guard_d = '0;
`endif
        th_last = sr_q[WORD_BITS-1] ? T1hLast : T0hLast;
        lo_last = sr_q[WORD_BITS-1] ? L1Last : L0Last;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (tx_en) begin
                    state_d = StHigh;
                    sr_d    = RGB;
                    idx_d   = IdxTop;
                end
            end
            StHigh: begin
                if (cnt_q == th_last) begin
                    state_d = StLow;
                    cnt_d   = '0;
                    // First LOW cycle of the last bit carries the per-word pulse.
                    done_d  = (idx_q == 5'd0);
                end
            end
            StLow: begin
                if (cnt_q == lo_last) begin
                    cnt_d = '0;
                    if (idx_q != 5'd0) begin
                        state_d = StHigh;
                        sr_d    = {sr_q[WORD_BITS-2:0], 1'b0};
                        idx_d   = idx_q - 5'd1;
                    end else if (tx_en) begin
                        state_d = StHigh;
                        sr_d    = RGB;
                        idx_d   = IdxTop;
                    end else begin
                        state_d = EndState;
                    end
                end
            end
`ifdef WS2812_RESET_GUARD_EN
            StGuard: begin
                cnt_d   = '0;
                guard_d = guard_q + 1'b1;
                if (guard_q == GuardLast) begin
                    state_d = StIdle;
                    guard_d = '0;
                end
            end
`endif
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (state_d == StIdle) begin
            done_d = 1'b1;
        end
        dout_d = (state_d == StHigh);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef WS2812_RESET_GUARD_EN
            state_q <= StGuard;
            guard_q <= '0;
`else
            state_q <= StIdle;
`endif
            cnt_q   <= '0;
            sr_q    <= '0;
            idx_q   <= 5'd0;
            dout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
`ifdef WS2812_RESET_GUARD_EN
            guard_q <= guard_d;
`endif
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    assign dout    = dout_q;
    assign tx_done = done_q;

endmodule

// File: doc/ws2812_tx_encoder.md
# ws2812_tx_encoder

Serial line encoder for WS2812 LED chains. Consumes 24-bit colour words from the frame-level RGB controller over an enable/done handshake and drives the single-wire NRZ pulse stream to the LED strip pin. Sits directly downstream of the controller and is the last stage before the I/O pad.

## Interface

- `T0H_CYC`, default 20: high time of a 0 bit, in clk cycles (0.40 us at 50 MHz).
- `T1H_CYC`, default 40: high time of a 1 bit, in cycles (0.80 us).
- `BIT_CYC`, default 62: full bit period, in cycles (1.24 us); must exceed `T1H_CYC` + 2.
- `RESET_CYC`, default 14000: minimum idle-low guard, in cycles (280 us); used only with the guard macro.
- Clocking and reset (already decided): one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  synchronous reset, active-high.
- `tx_en`  in  1  level; high = controller requests continuous word transmission.
- `RGB`  in  24  word to send, MSB first (wire order G7..G0, R7..R0, B7..B0 as packed by the controller).
- `tx_done`  out  1  one-cycle pulse per word while sending; held high while idle and ready.
- `dout`  out  1  registered serial data to the strip.

## Operation

- States: IDLE, HIGH, LOW (plus GUARD with the macro).
- IDLE: `dout`=0; `tx_done`=1. When `tx_en`=1, latch `RGB` into a 24-bit shift register, set bit index to 23, go to HIGH.
- HIGH: `dout`=1 for `T1H_CYC` cycles if the current bit is 1, or `T0H_CYC` cycles if it is 0. Then go to LOW.
- LOW: `dout`=0 for the remaining `BIT_CYC` − TH cycles.
  - If bits remain: shift left, decrement the index, go to HIGH.
  - If the last bit has finished and `tx_en`=1: latch `RGB`, index = 23, go to HIGH, with no gap between words.
  - If the last bit has finished and `tx_en`=0: go to IDLE.
- `tx_done` pulses for exactly one cycle on the first LOW cycle of bit 0 (the last bit sent) of each word. The controller updates `RGB` within 2 cycles of this pulse, and the latch happens ≥ 20 cycles later.
- `tx_en` is sampled only in IDLE and on the final LOW cycle of a word. A drop mid-word never truncates the word.
- Cycle counter width is $clog2(`BIT_CYC`); the bit index is 5 bits. The counter resets to 0 on every state entry.

## Timing

- Reset values: `dout`=0, `tx_done`=0, state IDLE, counter 0, shift register 0.
- In the first cycle after `rst` falls: `tx_done`=1 (without the macro).
- `tx_en` high in IDLE at cycle N means `dout`=1 from cycle N+1.
- Word length is exactly 24×`BIT_CYC` = 1488 cycles. Back-to-back words have zero added cycles.
- `tx_done` pulse occurs at word-relative cycle 23×62 + TH(bit 0), i.e. 1446 for a 0 bit or 1466 for a 1 bit.
- `rst` asserted mid-bit: `dout` is 0 on the next cycle and the partial word is abandoned.
- In IDLE, `tx_en` and `rst` together: reset wins.

## Configuration

- `WS2812_RESET_GUARD_EN` defined:
  - On entry to IDLE from LOW (and after reset), go to GUARD instead.
  - In GUARD, `dout`=0 and `tx_done`=0 for `RESET_CYC` cycles, then IDLE.
  - `tx_en` is ignored in GUARD.
  - This guarantees the latch/reset time independently of the controller.
- Macro undefined: no GUARD state. IDLE is reached directly and `tx_done` is high immediately.

## Structure

- Shared package `ws2812_pkg`: state enum (IDLE, HIGH, LOW, GUARD), default timing constants (`T0H_CYC`, `T1H_CYC`, `BIT_CYC`, `RESET_CYC` at 50 MHz), and the `WORD_BITS`=24 constant.
- Single module. No sub-module is needed; the guard counter lives inline under the macro.

## Test plan

- Single word `RGB`=24'h800000, `tx_en` pulsed for 1 cycle from IDLE -> first bit high 40 / low 22, the next 23 bits high 20 / low 42, one `tx_done` pulse at cycle 1446, then IDLE with `dout`=0.
- `tx_en` held high, `RGB` changed to 24'hFFFFFF 2 cycles after `tx_done` -> second word starts with no gap at cycle 1488, all bits high 40, and the second word matches the new value.
- Five-word burst as the controller produces, with `tx_en` dropped 1 cycle after the fifth `tx_done` -> exactly 5 `tx_done` pulses, 7440 cycles of activity, ending in IDLE.
- `rst` asserted at cycle 700 of a word -> `dout`=0 and `tx_done`=0 next cycle; after release, `tx_done`=1 and a fresh word sends correctly.
- Word 24'hAAAAAA -> alternating 40/22 and 20/42 patterns; a checker measures every high/low width exactly.
- With `WS2812_RESET_GUARD_EN` defined: after the word ends, `tx_done` stays 0 and `tx_en`=1 is ignored for 14000 cycles; `tx_done` rises at cycle 14001, and the next word starts one cycle after `tx_en` is seen.
